// File: rtl/axi4_burst_slv_sram.sv
// axi4_burst_slv_sram
//   AXI4 full-slave SRAM with FIXED/INCR/WRAP burst address generation,
//   byte-strobed writes, configurable read latency and SLVERR responses
//   for illegal bursts and WLAST protocol errors.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   MEM_AW*             write address channel (ID, ADDR, LEN, SIZE, BURST)
//   MEM_W*              write data channel (DATA, STRB, LAST)
//   MEM_B*              write response channel (ID, RESP)
//   MEM_AR*             read address channel (ID, ADDR, LEN, SIZE, BURST)
//   MEM_R*              read data channel (ID, DATA, RESP, LAST)
//
// The storage array is named `ram` so benches can preload or inspect it by
// hierarchical reference. It has no reset; RST only returns the FSMs to idle.
module axi4_burst_slv_sram #(
    parameter int DW     = 32,
    parameter int AW     = 18,
    parameter int IDW    = 4,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IDW-1:0]    MEM_AWID,
    input  logic [31:0]       MEM_AWADDR,
    input  logic [7:0]        MEM_AWLEN,
    input  logic [2:0]        MEM_AWSIZE,
    input  logic [1:0]        MEM_AWBURST,
    input  logic              MEM_AWVALID,
    output logic              MEM_AWREADY,
    input  logic [DW-1:0]     MEM_WDATA,
    input  logic [DW/8-1:0]   MEM_WSTRB,
    input  logic              MEM_WLAST,
    input  logic              MEM_WVALID,
    output logic              MEM_WREADY,
    output logic [IDW-1:0]    MEM_BID,
    output logic [1:0]        MEM_BRESP,
    output logic              MEM_BVALID,
    input  logic              MEM_BREADY,
    input  logic [IDW-1:0]    MEM_ARID,
    input  logic [31:0]       MEM_ARADDR,
    input  logic [7:0]        MEM_ARLEN,
    input  logic [2:0]        MEM_ARSIZE,
    input  logic [1:0]        MEM_ARBURST,
    input  logic              MEM_ARVALID,
    output logic              MEM_ARREADY,
    output logic [IDW-1:0]    MEM_RID,
    output logic [DW-1:0]     MEM_RDATA,
    output logic [1:0]        MEM_RRESP,
    output logic              MEM_RLAST,
    output logic              MEM_RVALID,
    input  logic              MEM_RREADY
);

    localparam int NB = DW / 8;
    localparam int B  = $clog2(NB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    // Address of the beat following `a` for the given burst shape.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [7:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] s;
        logic [31:0] m;
        s = 32'd1 << size;
        m = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~m) | ((a + s) & m);
            default: next_addr = a + s;
        endcase
    endfunction

    function automatic logic burst_illegal(input logic [31:0] a,
                                           input logic [7:0]  len,
                                           input logic [2:0]  size,
                                           input logic [1:0]  burst);
        logic bad;
        bad = 1'b0;
        if (burst == 2'b11) bad = 1'b1;
        if (int'(size) > B) bad = 1'b1;
        if (burst == 2'b10) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) bad = 1'b1;
            if ((a & ((32'd1 << size) - 32'd1)) != 32'd0) bad = 1'b1;
        end
        burst_illegal = bad;
    endfunction

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t       w_state_q, w_state_d;
    logic [31:0]    waddr_q, waddr_d;
    logic [7:0]     wlen_q, wlen_d;
    logic [2:0]     wsize_q, wsize_d;
    logic [1:0]     wburst_q, wburst_d;
    logic [IDW-1:0] wid_q, wid_d;
    logic [7:0]     wbeat_q, wbeat_d;
    logic           werr_q, werr_d;
    logic [1:0]     bresp_q, bresp_d;
    logic           w_last_beat;
    logic           ram_we;
    logic [AW-1:0]  ram_widx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wid_q     <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wid_q     <= wid_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            bresp_q   <= bresp_d;
        end
    end

    always_comb begin
        w_state_d   = w_state_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wsize_d     = wsize_q;
        wburst_d    = wburst_q;
        wid_d       = wid_q;
        wbeat_d     = wbeat_q;
        werr_d      = werr_q;
        bresp_d     = bresp_q;
        w_last_beat = (wbeat_q == wlen_q);
        case (w_state_q)
            W_IDLE: begin
                if (MEM_AWVALID) begin
                    w_state_d = W_DATA;
                    waddr_d   = MEM_AWADDR;
                    wlen_d    = MEM_AWLEN;
                    wsize_d   = MEM_AWSIZE;
                    wburst_d  = MEM_AWBURST;
                    wid_d     = MEM_AWID;
                    wbeat_d   = 8'd0;
                    werr_d    = burst_illegal(MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST);
                end
            end
            W_DATA: begin
                if (MEM_WVALID) begin
                    // The burst ends on whichever comes first: WLAST or beat len.
                    // A mismatch between the two is a protocol error.
                    if (MEM_WLAST || w_last_beat) begin
                        w_state_d = W_RESP;
                        bresp_d   = (werr_q || !(MEM_WLAST && w_last_beat)) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wbeat_d = wbeat_q + 8'd1;
                        waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    end
                end
            end
            W_RESP: begin
                if (MEM_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign MEM_AWREADY = (w_state_q == W_IDLE);
    assign MEM_WREADY  = (w_state_q == W_DATA);
    assign MEM_BVALID  = (w_state_q == W_RESP);
    assign MEM_BID     = wid_q;
    assign MEM_BRESP   = bresp_q;

    // Illegal bursts still consume their beats but never touch the array.
    assign ram_we   = (w_state_q == W_DATA) && MEM_WVALID && !werr_q;
    assign ram_widx = waddr_q[AW+B-1:B];

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    r_state_t       r_state_q, r_state_d;
    logic [31:0]    raddr_q, raddr_d;
    logic [7:0]     rlen_q, rlen_d;
    logic [2:0]     rsize_q, rsize_d;
    logic [1:0]     rburst_q, rburst_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [7:0]     rbeat_q, rbeat_d;
    logic           rerr_q, rerr_d;
    logic [1:0]     rresp_q, rresp_d;
    logic           rlast_q, rlast_d;
    logic [2:0]     rwait_cnt_q, rwait_cnt_d;
    logic           rd_zero_q, rd_zero_d;
    logic [31:0]    r_next_addr;
    logic           rd_load;
    logic [AW-1:0]  rd_load_idx;
    logic [DW-1:0]  ram_rd_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q   <= R_IDLE;
            raddr_q     <= '0;
            rlen_q      <= '0;
            rsize_q     <= '0;
            rburst_q    <= '0;
            rid_q       <= '0;
            rbeat_q     <= '0;
            rerr_q      <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rlast_q     <= 1'b0;
            rwait_cnt_q <= '0;
            rd_zero_q   <= 1'b1;
        end else begin
            r_state_q   <= r_state_d;
            raddr_q     <= raddr_d;
            rlen_q      <= rlen_d;
            rsize_q     <= rsize_d;
            rburst_q    <= rburst_d;
            rid_q       <= rid_d;
            rbeat_q     <= rbeat_d;
            rerr_q      <= rerr_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
            rwait_cnt_q <= rwait_cnt_d;
            rd_zero_q   <= rd_zero_d;
        end
    end

    assign r_next_addr = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);

    // rd_load captures the array word for the beat about to be presented;
    // the captured word then stays put until RREADY moves the burst on.
    always_comb begin
        r_state_d   = r_state_q;
        raddr_d     = raddr_q;
        rlen_d      = rlen_q;
        rsize_d     = rsize_q;
        rburst_d    = rburst_q;
        rid_d       = rid_q;
        rbeat_d     = rbeat_q;
        rerr_d      = rerr_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rwait_cnt_d = rwait_cnt_q;
        rd_zero_d   = rd_zero_q;
        rd_load     = 1'b0;
        rd_load_idx = raddr_q[AW+B-1:B];
        case (r_state_q)
            R_IDLE: begin
                if (MEM_ARVALID) begin
                    raddr_d     = MEM_ARADDR;
                    rlen_d      = MEM_ARLEN;
                    rsize_d     = MEM_ARSIZE;
                    rburst_d    = MEM_ARBURST;
                    rid_d       = MEM_ARID;
                    rbeat_d     = 8'd0;
                    rwait_cnt_d = 3'd0;
                    rerr_d      = burst_illegal(MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST);
                    rresp_d     = rerr_d ? RESP_SLVERR : RESP_OKAY;
                    rlast_d     = (MEM_ARLEN == 8'd0);
                    if (RD_LAT == 1) begin
                        r_state_d   = R_DATA;
                        rd_load     = 1'b1;
                        rd_load_idx = MEM_ARADDR[AW+B-1:B];
                        rd_zero_d   = rerr_d;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rwait_cnt_q == 3'(RD_LAT - 2)) begin
                    r_state_d   = R_DATA;
                    rd_load     = 1'b1;
                    rd_load_idx = raddr_q[AW+B-1:B];
                    rd_zero_d   = rerr_q;
                end else begin
                    rwait_cnt_d = rwait_cnt_q + 3'd1;
                end
            end
            R_DATA: begin
                if (MEM_RREADY) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        raddr_d     = r_next_addr;
                        rbeat_d     = rbeat_q + 8'd1;
                        rlast_d     = ((rbeat_q + 8'd1) == rlen_q);
                        rd_load     = 1'b1;
                        rd_load_idx = r_next_addr[AW+B-1:B];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign MEM_ARREADY = (r_state_q == R_IDLE);
    assign MEM_RVALID  = (r_state_q == R_DATA);
    assign MEM_RLAST   = rlast_q && (r_state_q == R_DATA);
    assign MEM_RID     = rid_q;
    assign MEM_RRESP   = rresp_q;
    assign MEM_RDATA   = rd_zero_q ? '0 : ram_rd_q;

    // ------------------------------------------------------------------
    // Storage: byte-strobed write, registered read. Both use non-blocking
    // assignment on the same edge, so a same-cycle read sees the old word.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int i = 0; i < NB; i++) begin
                if (MEM_WSTRB[i]) ram[ram_widx][i*8 +: 8] <= MEM_WDATA[i*8 +: 8];
            end
        end
        if (rd_load) ram_rd_q <= ram[rd_load_idx];
    end

endmodule

// File: tb/tb_axi4_burst_slv_sram.sv
module tb_axi4_burst_slv_sram;

    localparam int DW  = 32;
    localparam int AW  = 18;
    localparam int IDW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // Shared stimulus; the VALIDs are steered to one DUT by sel3.
    logic           sel3 = 1'b0;
    logic [IDW-1:0] awid = '0, arid = '0;
    logic [31:0]    awaddr = '0, araddr = '0;
    logic [7:0]     awlen = '0, arlen = '0;
    logic [2:0]     awsize = '0, arsize = '0;
    logic [1:0]     awburst = '0, arburst = '0;
    logic           awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic [DW-1:0]  wdata = '0;
    logic [3:0]     wstrb = 4'hF;
    logic           wlast = 1'b0, bready = 1'b0, rready = 1'b0;

    logic awready_1, wready_1, bvalid_1, arready_1, rvalid_1, rlast_1;
    logic awready_3, wready_3, bvalid_3, arready_3, rvalid_3, rlast_3;
    logic [IDW-1:0] bid_1, rid_1, bid_3, rid_3;
    logic [1:0] bresp_1, rresp_1, bresp_3, rresp_3;
    logic [DW-1:0] rdata_1, rdata_3;

    logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
    logic [IDW-1:0] s_bid, s_rid;
    logic [1:0] s_bresp, s_rresp;
    logic [DW-1:0] s_rdata;

    assign s_awready = sel3 ? awready_3 : awready_1;
    assign s_wready  = sel3 ? wready_3  : wready_1;
    assign s_bvalid  = sel3 ? bvalid_3  : bvalid_1;
    assign s_bid     = sel3 ? bid_3     : bid_1;
    assign s_bresp   = sel3 ? bresp_3   : bresp_1;
    assign s_arready = sel3 ? arready_3 : arready_1;
    assign s_rvalid  = sel3 ? rvalid_3  : rvalid_1;
    assign s_rid     = sel3 ? rid_3     : rid_1;
    assign s_rdata   = sel3 ? rdata_3   : rdata_1;
    assign s_rresp   = sel3 ? rresp_3   : rresp_1;
    assign s_rlast   = sel3 ? rlast_3   : rlast_1;

    axi4_burst_slv_sram #(.DW(DW), .AW(AW), .IDW(IDW), .RD_LAT(1)) u_dut (
        .CLK(CLK), .RST(RST),
        .MEM_AWID(awid), .MEM_AWADDR(awaddr), .MEM_AWLEN(awlen), .MEM_AWSIZE(awsize),
        .MEM_AWBURST(awburst), .MEM_AWVALID(awvalid && !sel3), .MEM_AWREADY(awready_1),
        .MEM_WDATA(wdata), .MEM_WSTRB(wstrb), .MEM_WLAST(wlast),
        .MEM_WVALID(wvalid && !sel3), .MEM_WREADY(wready_1),
        .MEM_BID(bid_1), .MEM_BRESP(bresp_1), .MEM_BVALID(bvalid_1), .MEM_BREADY(bready),
        .MEM_ARID(arid), .MEM_ARADDR(araddr), .MEM_ARLEN(arlen), .MEM_ARSIZE(arsize),
        .MEM_ARBURST(arburst), .MEM_ARVALID(arvalid && !sel3), .MEM_ARREADY(arready_1),
        .MEM_RID(rid_1), .MEM_RDATA(rdata_1), .MEM_RRESP(rresp_1), .MEM_RLAST(rlast_1),
        .MEM_RVALID(rvalid_1), .MEM_RREADY(rready)
    );

    axi4_burst_slv_sram #(.DW(DW), .AW(AW), .IDW(IDW), .RD_LAT(3)) u_dut3 (
        .CLK(CLK), .RST(RST),
        .MEM_AWID(awid), .MEM_AWADDR(awaddr), .MEM_AWLEN(awlen), .MEM_AWSIZE(awsize),
        .MEM_AWBURST(awburst), .MEM_AWVALID(awvalid && sel3), .MEM_AWREADY(awready_3),
        .MEM_WDATA(wdata), .MEM_WSTRB(wstrb), .MEM_WLAST(wlast),
        .MEM_WVALID(wvalid && sel3), .MEM_WREADY(wready_3),
        .MEM_BID(bid_3), .MEM_BRESP(bresp_3), .MEM_BVALID(bvalid_3), .MEM_BREADY(bready),
        .MEM_ARID(arid), .MEM_ARADDR(araddr), .MEM_ARLEN(arlen), .MEM_ARSIZE(arsize),
        .MEM_ARBURST(arburst), .MEM_ARVALID(arvalid && sel3), .MEM_ARREADY(arready_3),
        .MEM_RID(rid_3), .MEM_RDATA(rdata_3), .MEM_RRESP(rresp_3), .MEM_RLAST(rlast_3),
        .MEM_RVALID(rvalid_3), .MEM_RREADY(rready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]    wd [16];
    logic [31:0]    rd_data [16];
    logic [1:0]     rd_resp [16];
    logic           rd_last [16];
    int             rd_lat;
    int             rd_nbeats;
    logic [IDW-1:0] got_bid, got_rid;
    logic [1:0]     got_bresp;

    task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int nb, input int lastb);
        logic hs;
        @(posedge CLK); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge CLK); hs = s_awready;
            @(posedge CLK); #1;
        end
        awvalid = 1'b0;
        n_cmp++;
        if (!hs) begin n_fail++; $display("FAIL aw_handshake: timeout, want AWREADY within 20 cycles"); end
        for (int b = 0; b < nb; b++) begin
            wdata = wd[b]; wlast = (b == lastb); wvalid = 1'b1;
            hs = 1'b0;
            for (int t = 0; t < 20 && !hs; t++) begin
                @(negedge CLK); hs = s_wready;
                @(posedge CLK); #1;
            end
            if (!hs) begin n_cmp++; n_fail++; $display("FAIL w_handshake: beat %0d timeout", b); end
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        hs = 1'b0;
        got_bid = '1; got_bresp = 2'b11;
        for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge CLK);
            if (s_bvalid) begin hs = 1'b1; got_bid = s_bid; got_bresp = s_bresp; end
            @(posedge CLK); #1;
        end
        bready = 1'b0;
        n_cmp++;
        if (!hs) begin n_fail++; $display("FAIL b_handshake: timeout, want BVALID within 20 cycles"); end
        $display("write id=%0d addr=%h len=%0d burst=%0d beats=%0d -> bid=%0d bresp=%0d",
                 id, addr, len, burst, nb, got_bid, got_bresp);
    endtask

    // pat bit (c-1)%4 is RREADY during cycle c after the AR handshake.
    task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] pat);
        logic hs, have_prev, prev_last;
        logic [DW-1:0] prev_data;
        int nb;
        @(posedge CLK); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge CLK); hs = s_arready;
            @(posedge CLK); #1;
        end
        arvalid = 1'b0;
        n_cmp++;
        if (!hs) begin n_fail++; $display("FAIL ar_handshake: timeout, want ARREADY within 20 cycles"); end
        nb = 0; rd_lat = 0; have_prev = 1'b0; prev_last = 1'b0; prev_data = '0;
        for (int c = 1; c < 200 && nb <= int'(len); c++) begin
            rready = pat[(c-1)%4];
            @(negedge CLK);
            if (s_rvalid) begin
                if (rd_lat == 0) rd_lat = c;
                if (have_prev) begin
                    n_cmp++;
                    if (s_rdata !== prev_data || s_rlast !== prev_last) begin
                        n_fail++;
                        $display("FAIL rd_stable: beat %0d data=%h last=%b, required data=%h last=%b",
                                 nb, s_rdata, s_rlast, prev_data, prev_last);
                    end
                end
                if (rready) begin
                    rd_data[nb] = s_rdata; rd_resp[nb] = s_rresp; rd_last[nb] = s_rlast;
                    got_rid = s_rid; nb++; have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1; prev_data = s_rdata; prev_last = s_rlast;
                end
            end
            @(posedge CLK); #1;
        end
        rready = 1'b0;
        rd_nbeats = nb;
        n_cmp++;
        if (nb != int'(len) + 1) begin
            n_fail++;
            $display("FAIL rd_beats: got %0d beats, required %0d", nb, int'(len) + 1);
        end
        $display("read id=%0d addr=%h len=%0d burst=%0d -> rid=%0d beats=%0d latency=%0d",
                 id, addr, len, burst, got_rid, nb, rd_lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({awready_1, arready_1, awready_3, arready_3} !== 4'b1111) begin
            n_fail++; $display("FAIL rst_ready: got %b, required 1111", {awready_1, arready_1, awready_3, arready_3});
        end
        n_cmp++;
        if ({wready_1, bvalid_1, rvalid_1, rlast_1} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_valid: got %b, required 0000", {wready_1, bvalid_1, rvalid_1, rlast_1});
        end
        n_cmp++;
        if ({bid_1, rid_1, bresp_1, rresp_1} !== 12'h000) begin
            n_fail++; $display("FAIL rst_id_resp: got %h, required 000", {bid_1, rid_1, bresp_1, rresp_1});
        end
        n_cmp++;
        if (rdata_1 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h, required 0", rdata_1); end
        RST = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if ({awready_1, arready_1, wready_1, bvalid_1, rvalid_1} !== 5'b11000) begin
            n_fail++; $display("FAIL post_rst: got %b, required 11000", {awready_1, arready_1, wready_1, bvalid_1, rvalid_1});
        end
    endtask

    task automatic test_incr();
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        do_write(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 4, 3);
        n_cmp++;
        if (got_bid !== 4'd5 || got_bresp !== 2'b00) begin
            n_fail++; $display("FAIL incr_b: bid=%0d bresp=%0d, required bid=5 bresp=0", got_bid, got_bresp);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (u_dut.ram[32'h40 + i] !== wd[i]) begin
                n_fail++; $display("FAIL incr_ram: idx %h = %h, required %h", 32'h40 + i, u_dut.ram[32'h40 + i], wd[i]);
            end
        end
        do_read(4'd9, 32'h100, 8'd3, 3'd2, 2'b01, 4'b1111);
        n_cmp++;
        if (rd_lat != 1 || got_rid !== 4'd9) begin
            n_fail++; $display("FAIL incr_rlat: latency=%0d rid=%0d, required 1 and 9", rd_lat, got_rid);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== wd[i] || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL incr_rbeat: beat %0d data=%h resp=%0d last=%b, required %h 0 %b",
                                   i, rd_data[i], rd_resp[i], rd_last[i], wd[i], (i == 3));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] widx [4];
        widx[0] = 32'h42; widx[1] = 32'h43; widx[2] = 32'h40; widx[3] = 32'h41;
        wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3; wd[3] = 32'hA4;
        do_write(4'd6, 32'h108, 8'd3, 3'd2, 2'b10, 4, 3);
        n_cmp++;
        if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL wrap_b: bresp=%0d, required 0", got_bresp); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (u_dut.ram[widx[i]] !== wd[i]) begin
                n_fail++; $display("FAIL wrap_ram: idx %h = %h, required %h", widx[i], u_dut.ram[widx[i]], wd[i]);
            end
        end
        do_read(4'd7, 32'h108, 8'd3, 3'd2, 2'b10, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== wd[i] || rd_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL wrap_rbeat: beat %0d data=%h last=%b, required %h %b",
                                   i, rd_data[i], rd_last[i], wd[i], (i == 3));
            end
        end
    endtask

    task automatic test_rd_lat3();
        sel3 = 1'b1;
        wd[0] = 32'h5000_0001; wd[1] = 32'h5000_0002; wd[2] = 32'h5000_0003; wd[3] = 32'h5000_0004;
        do_write(4'd3, 32'h800, 8'd3, 3'd2, 2'b01, 4, 3);
        n_cmp++;
        if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL lat3_b: bresp=%0d, required 0", got_bresp); end
        do_read(4'd3, 32'h800, 8'd3, 3'd2, 2'b01, 4'b1001);
        n_cmp++;
        if (rd_lat != 3) begin n_fail++; $display("FAIL lat3_latency: got %0d, required 3", rd_lat); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== wd[i] || rd_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL lat3_rbeat: beat %0d data=%h last=%b, required %h %b",
                                   i, rd_data[i], rd_last[i], wd[i], (i == 3));
            end
        end
        sel3 = 1'b0;
    endtask

    task automatic test_illegal();
        wd[0] = 32'h7777_0000; wd[1] = 32'h7777_0001;
        do_write(4'd2, 32'h300, 8'd1, 3'd2, 2'b01, 2, 1);
        wd[0] = 32'hDEAD_0000; wd[1] = 32'hDEAD_0001;
        do_write(4'd2, 32'h300, 8'd1, 3'd2, 2'b11, 2, 1);
        n_cmp++;
        if (got_bresp !== 2'b10 || got_bid !== 4'd2) begin
            n_fail++; $display("FAIL ill_b: bresp=%0d bid=%0d, required 2 and 2", got_bresp, got_bid);
        end
        n_cmp++;
        if (u_dut.ram[32'hC0] !== 32'h7777_0000 || u_dut.ram[32'hC1] !== 32'h7777_0001) begin
            n_fail++; $display("FAIL ill_ram: %h %h, required 77770000 77770001", u_dut.ram[32'hC0], u_dut.ram[32'hC1]);
        end
        do_read(4'd4, 32'h100, 8'd2, 3'd2, 2'b10, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 2)) begin
                n_fail++; $display("FAIL ill_rbeat: beat %0d data=%h resp=%0d last=%b, required 0 2 %b",
                                   i, rd_data[i], rd_resp[i], rd_last[i], (i == 2));
            end
        end
    endtask

    task automatic test_wlast();
        wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; wd[3] = 32'hC3;
        do_write(4'd1, 32'h400, 8'd3, 3'd2, 2'b01, 4, 3);
        wd[0] = 32'hB0; wd[1] = 32'hB1;
        do_write(4'd1, 32'h400, 8'd3, 3'd2, 2'b01, 2, 1);
        n_cmp++;
        if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL early_wlast_b: bresp=%0d, required 2", got_bresp); end
        n_cmp++;
        if (u_dut.ram[32'h100] !== 32'hB0 || u_dut.ram[32'h101] !== 32'hB1 ||
            u_dut.ram[32'h102] !== 32'hC2 || u_dut.ram[32'h103] !== 32'hC3) begin
            n_fail++; $display("FAIL early_wlast_ram: %h %h %h %h, required b0 b1 c2 c3",
                               u_dut.ram[32'h100], u_dut.ram[32'h101], u_dut.ram[32'h102], u_dut.ram[32'h103]);
        end
        do_write(4'd1, 32'h500, 8'd1, 3'd2, 2'b01, 2, 255);
        n_cmp++;
        if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL missing_wlast_b: bresp=%0d, required 2", got_bresp); end
        // FIXED burst keeps hammering one word; a strobed single beat then patches lanes 0 and 2.
        wd[0] = 32'hD0D0D0D0; wd[1] = 32'hD1D1D1D1; wd[2] = 32'hD2D2D2D2;
        do_write(4'd1, 32'h600, 8'd2, 3'd2, 2'b00, 3, 2);
        n_cmp++;
        if (got_bresp !== 2'b00 || u_dut.ram[32'h180] !== 32'hD2D2D2D2 || u_dut.ram[32'h181] === 32'hD1D1D1D1) begin
            n_fail++; $display("FAIL fixed_ram: bresp=%0d word=%h, required 0 d2d2d2d2", got_bresp, u_dut.ram[32'h180]);
        end
        wstrb = 4'b0101; wd[0] = 32'h12345678;
        do_write(4'd1, 32'h600, 8'd0, 3'd2, 2'b00, 1, 0);
        wstrb = 4'hF;
        n_cmp++;
        if (u_dut.ram[32'h180] !== 32'hD234D278) begin
            n_fail++; $display("FAIL strobe_ram: word=%h, required d234d278", u_dut.ram[32'h180]);
        end
    endtask

    task automatic test_reset_mid();
        logic hs;
        int seen;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hA3; exp_d[1] = 32'hA4; exp_d[2] = 32'hA1; exp_d[3] = 32'hA2;
        @(posedge CLK); #1;
        arid = 4'd10; araddr = 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge CLK); hs = s_arready;
            @(posedge CLK); #1;
        end
        arvalid = 1'b0; rready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge CLK);
            if (s_rvalid) seen++;
            if (seen < 3) begin @(posedge CLK); #1; end
        end
        n_cmp++;
        if (seen != 3) begin n_fail++; $display("FAIL rstmid_reach: saw %0d beats, required 3", seen); end
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if (rvalid_1 !== 1'b0 || arready_1 !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_state: rvalid=%b arready=%b, required 0 1", rvalid_1, arready_1);
        end
        rready = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        $display("read id=10 addr=00000100 len=7 interrupted by reset after %0d beats", seen);
        n_cmp++;
        if (u_dut.ram[32'h40] !== 32'hA3 || u_dut.ram[32'h43] !== 32'hA2) begin
            n_fail++; $display("FAIL rstmid_ram: %h %h, required a3 a2", u_dut.ram[32'h40], u_dut.ram[32'h43]);
        end
        do_read(4'd8, 32'h100, 8'd3, 3'd2, 2'b01, 4'b1111);
        n_cmp++;
        if (got_rid !== 4'd8 || rd_lat != 1) begin
            n_fail++; $display("FAIL rstmid_rid: rid=%0d latency=%0d, required 8 and 1", got_rid, rd_lat);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== exp_d[i] || rd_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL rstmid_rbeat: beat %0d data=%h last=%b, required %h %b",
                                   i, rd_data[i], rd_last[i], exp_d[i], (i == 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_rd_lat3();
        test_illegal();
        test_wlast();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
